// File: rtl/packet_snapper.sv
// packet_snapper: truncates AXI4-Stream packets to a runtime snap length and rewrites TUSER[15:0].
// Optional build macro SNAPPER_ORIG_LEN_EN: TUSER[31:16] carries the original length, MSB = trunc.
module packet_snapper #(
   parameter int unsigned DATA_WIDTH     = 256,
   parameter int unsigned TUSER_WIDTH    = 128,
   parameter int unsigned MIN_SNAP_BYTES = 64,
   parameter int unsigned CNT_WIDTH      = 32
) (
   input  logic                    axi_aclk,
   input  logic                    axi_reset,
   input  logic                    snap_en,
   input  logic [15:0]             snap_len,
   input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
   input  logic [TUSER_WIDTH-1:0]  s_axis_tuser,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   input  logic                    s_axis_tlast,
   output logic [DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
   output logic [TUSER_WIDTH-1:0]  m_axis_tuser,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic                    m_axis_tlast,
   output logic [CNT_WIDTH-1:0]    pkt_in_cnt,
   output logic [CNT_WIDTH-1:0]    pkt_trunc_cnt
);

   localparam int unsigned BYTES   = DATA_WIDTH / 8;
   localparam int unsigned SHIFT   = $clog2(BYTES);
   localparam int unsigned RW      = SHIFT + 1;
   localparam logic [15:0] MinSnap = 16'(MIN_SNAP_BYTES);

   typedef enum logic [1:0] {StSop, StPass, StDrop} state_e;

   state_e                 state_q;
   logic [15:0]            last_idx_q;
   logic [15:0]            beat_cnt_q;
   logic [RW-1:0]          rem_q;
   logic                   trunc_q;
   logic [TUSER_WIDTH-1:0] tuser_q;

   logic [15:0]            orig;
   logic [15:0]            lim;
   logic [15:0]            eff;
   logic [15:0]            eff_m1;
   logic [15:0]            last_idx;
   logic [RW-1:0]          rem;
   logic                   trunc;
   logic [TUSER_WIDTH-1:0] sop_tuser;
   logic [BYTES-1:0]       sop_mask;
   logic [BYTES-1:0]       pass_mask;
   logic                   accept;

   function automatic logic [BYTES-1:0] keep_mask(input logic [RW-1:0] n);
      logic [BYTES-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < BYTES; i++) begin
         m[i] = (RW'(i) < n);
      end
      return m;
   endfunction

   // Length arithmetic for the SOP beat; only meaningful when the current beat is a SOP.
   always_comb begin
      orig      = s_axis_tuser[15:0];
      lim       = (snap_len < MinSnap) ? MinSnap : snap_len;
      eff       = (snap_en && (snap_len != 16'd0) && (lim < orig)) ? lim : orig;
      eff_m1    = eff - 16'd1;
      last_idx  = eff_m1 >> SHIFT;
      rem       = RW'(eff_m1[SHIFT-1:0]) + RW'(1);
      trunc     = (eff != orig);
      sop_tuser = s_axis_tuser;
      sop_tuser[15:0] = eff;
`ifdef SNAPPER_ORIG_LEN_EN
      sop_tuser[31:16]           = orig;
      sop_tuser[TUSER_WIDTH-1]   = trunc;
`endif
      sop_mask  = keep_mask(rem);
      pass_mask = keep_mask(rem_q);
   end

   // DROP never writes the output register, so it may accept even while a beat is held.
   assign s_axis_tready = (state_q == StDrop) | ~m_axis_tvalid | m_axis_tready;
   assign accept        = s_axis_tvalid & s_axis_tready;

   always_ff @(posedge axi_aclk) begin
      if (axi_reset) begin
         state_q       <= StSop;
         last_idx_q    <= '0;
         beat_cnt_q    <= '0;
         rem_q         <= '0;
         trunc_q       <= 1'b0;
         tuser_q       <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tkeep  <= '0;
         m_axis_tuser  <= '0;
         pkt_in_cnt    <= '0;
         pkt_trunc_cnt <= '0;
      end else begin
         if (m_axis_tvalid && m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
         end
         if (accept) begin
            unique case (state_q)
               StSop: begin
                  last_idx_q    <= last_idx;
                  rem_q         <= rem;
                  trunc_q       <= trunc;
                  tuser_q       <= sop_tuser;
                  beat_cnt_q    <= 16'd1;
                  pkt_in_cnt    <= pkt_in_cnt + CNT_WIDTH'(1);
                  if (trunc) begin
                     pkt_trunc_cnt <= pkt_trunc_cnt + CNT_WIDTH'(1);
                  end
                  m_axis_tvalid <= 1'b1;
                  m_axis_tdata  <= s_axis_tdata;
                  m_axis_tuser  <= sop_tuser;
                  if (trunc && (last_idx == 16'd0)) begin
                     m_axis_tkeep <= s_axis_tkeep & sop_mask;
                     m_axis_tlast <= 1'b1;
                     state_q      <= s_axis_tlast ? StSop : StDrop;
                  end else begin
                     m_axis_tkeep <= s_axis_tkeep;
                     m_axis_tlast <= s_axis_tlast;
                     state_q      <= s_axis_tlast ? StSop : StPass;
                  end
               end
               StPass: begin
                  beat_cnt_q    <= beat_cnt_q + 16'd1;
                  m_axis_tvalid <= 1'b1;
                  m_axis_tdata  <= s_axis_tdata;
                  m_axis_tuser  <= tuser_q;
                  if (trunc_q && (beat_cnt_q == last_idx_q)) begin
                     m_axis_tkeep <= s_axis_tkeep & pass_mask;
                     m_axis_tlast <= 1'b1;
                     state_q      <= s_axis_tlast ? StSop : StDrop;
                  end else begin
                     m_axis_tkeep <= s_axis_tkeep;
                     m_axis_tlast <= s_axis_tlast;
                     if (s_axis_tlast) begin
                        state_q <= StSop;
                     end
                  end
               end
               StDrop: begin
                  if (s_axis_tlast) begin
                     state_q <= StSop;
                  end
               end
               default: state_q <= StSop;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_packet_snapper.sv
// Self-checking bench for packet_snapper: directed scenarios plus randomized traffic
// compared against a byte-count reference model.
`timescale 1ns/1ps
module tb_packet_snapper;

   localparam int DW = 256;
   localparam int UW = 128;
   localparam int CW = 32;
   localparam int NB = DW / 8;

   logic          axi_aclk = 1'b0;
   logic          axi_reset;
   logic          snap_en;
   logic [15:0]   snap_len;
   logic [DW-1:0] s_axis_tdata;
   logic [NB-1:0] s_axis_tkeep;
   logic [UW-1:0] s_axis_tuser;
   logic          s_axis_tvalid;
   logic          s_axis_tready;
   logic          s_axis_tlast;
   logic [DW-1:0] m_axis_tdata;
   logic [NB-1:0] m_axis_tkeep;
   logic [UW-1:0] m_axis_tuser;
   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic          m_axis_tlast;
   logic [CW-1:0] pkt_in_cnt;
   logic [CW-1:0] pkt_trunc_cnt;

   packet_snapper #(
      .DATA_WIDTH    (DW),
      .TUSER_WIDTH   (UW),
      .MIN_SNAP_BYTES(64),
      .CNT_WIDTH     (CW)
   ) dut (
      .axi_aclk     (axi_aclk),
      .axi_reset    (axi_reset),
      .snap_en      (snap_en),
      .snap_len     (snap_len),
      .s_axis_tdata (s_axis_tdata),
      .s_axis_tkeep (s_axis_tkeep),
      .s_axis_tuser (s_axis_tuser),
      .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready),
      .s_axis_tlast (s_axis_tlast),
      .m_axis_tdata (m_axis_tdata),
      .m_axis_tkeep (m_axis_tkeep),
      .m_axis_tuser (m_axis_tuser),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready),
      .m_axis_tlast (m_axis_tlast),
      .pkt_in_cnt   (pkt_in_cnt),
      .pkt_trunc_cnt(pkt_trunc_cnt)
   );

   always #5 axi_aclk = ~axi_aclk;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [NB-1:0] keep;
      logic [UW-1:0] user;
      logic          last;
   } beat_t;

   beat_t exp_q[$];
   beat_t obs_q[$];
   int    checks     = 0;
   int    failures   = 0;
   int    exp_in     = 0;
   int    exp_trunc  = 0;
   int    ready_mode = 0;
   int    stable_err = 0;
   int    last_stall = 0;

   logic [DW-1:0] pk_data[16];
   logic [NB-1:0] pk_keep[16];
   logic [UW-1:0] pk_user;
   int            pk_n;

   function automatic logic [NB-1:0] keep_of(int n);
      logic [NB-1:0] k;
      k = '0;
      for (int i = 0; i < NB; i++) if (i < n) k[i] = 1'b1;
      return k;
   endfunction

   // Output-ready pattern: 0 = always ready, 1 = 50% random, 2 = stalled.
   initial begin
      m_axis_tready = 1'b1;
      forever begin
         @(negedge axi_aclk);
         case (ready_mode)
            1:       m_axis_tready = 1'($urandom_range(0, 1));
            2:       m_axis_tready = 1'b0;
            default: m_axis_tready = 1'b1;
         endcase
      end
   end

   // Collects every output handshake and flags any change of a stalled output beat.
   initial begin : monitor
      beat_t prev;
      beat_t cur;
      bit    prev_stall;
      bit    prev_rst;
      prev       = '0;
      prev_stall = 1'b0;
      prev_rst   = 1'b1;
      forever begin
         @(negedge axi_aclk);
         #2;
         cur = {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast};
         if (prev_stall && !prev_rst && (cur !== prev || m_axis_tvalid !== 1'b1)) stable_err++;
         if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) obs_q.push_back(cur);
         prev_stall = (m_axis_tvalid === 1'b1) && (m_axis_tready === 1'b0);
         prev_rst   = (axi_reset !== 1'b0);
         prev       = cur;
      end
   end

   task automatic gen_pkt(int len);
      pk_n = (len + NB - 1) / NB;
      for (int k = 0; k < pk_n; k++) begin
         pk_data[k] = {$urandom, $urandom, $urandom, $urandom,
                       $urandom, $urandom, $urandom, $urandom};
         pk_keep[k] = (k == pk_n - 1) ? keep_of(len - NB * k) : '1;
      end
      pk_user = {$urandom, $urandom, $urandom, $urandom};
      pk_user[15:0] = 16'(len);
   endtask

   // Reference: keep the first eff bytes of the packet, everything else disappears.
   task automatic model_pkt(int len, bit en, int slen);
      int    lim;
      int    eff;
      int    nout;
      bit    trunc;
      beat_t b;
      lim   = (slen < 64) ? 64 : slen;
      eff   = (en && slen != 0 && lim < len) ? lim : len;
      trunc = (eff != len);
      nout  = trunc ? (eff + NB - 1) / NB : pk_n;
      exp_in++;
      if (trunc) exp_trunc++;
      for (int k = 0; k < nout; k++) begin
         b.data = pk_data[k];
         b.keep = pk_keep[k];
         if (trunc && k == nout - 1) b.keep = b.keep & keep_of(eff - NB * k);
         b.user = pk_user;
         b.user[15:0] = 16'(eff);
`ifdef SNAPPER_ORIG_LEN_EN
         b.user[31:16] = 16'(len);
         b.user[UW-1]  = trunc;
`endif
         b.last = (k == nout - 1);
         exp_q.push_back(b);
      end
   endtask

   task automatic drive_beat(int k, bit en, int slen);
      int stall;
      stall = 0;
      @(negedge axi_aclk);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = pk_data[k];
      s_axis_tkeep  = pk_keep[k];
      s_axis_tuser  = (k == 0) ? pk_user : {$urandom, $urandom, $urandom, $urandom};
      s_axis_tlast  = (k == pk_n - 1);
      snap_en       = en;
      snap_len      = 16'(slen);
      #2;
      while (s_axis_tready !== 1'b1) begin
         @(negedge axi_aclk);
         #2;
         stall++;
         if (stall > 5000) begin
            $display("FAIL drive_timeout beat=%0d stalled=%0d limit=5000", k, stall);
            $fatal(1, "input handshake never completed");
         end
      end
      last_stall = stall;
      @(posedge axi_aclk);
   endtask

   task automatic send_pkt(int len, bit en, int slen, int mid_slen);
      gen_pkt(len);
      model_pkt(len, en, slen);
      for (int k = 0; k < pk_n; k++) begin
         if (k == 0) drive_beat(k, en, slen);
         else if (mid_slen >= 0) drive_beat(k, en, mid_slen);
         else drive_beat(k, 1'($urandom_range(0, 1)), int'($urandom_range(0, 400)));
      end
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      @(negedge axi_aclk);
      s_axis_tvalid = 1'b0;
      ready_mode    = 0;
      while (obs_q.size() < exp_q.size() && n < 400) begin
         @(negedge axi_aclk);
         n++;
      end
      repeat (5) @(negedge axi_aclk);
   endtask

   task automatic pulse_reset();
      @(negedge axi_aclk);
      axi_reset     = 1'b1;
      s_axis_tvalid = 1'b0;
      repeat (2) @(negedge axi_aclk);
      axi_reset = 1'b0;
      obs_q.delete();
      exp_q.delete();
      exp_in    = 0;
      exp_trunc = 0;
   endtask

   task automatic test_reset();
      axi_reset = 1'b1;
      repeat (3) @(negedge axi_aclk);
      #2;
      checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL rst_tvalid got=%b exp=0", m_axis_tvalid); end
      checks++; if (m_axis_tlast !== 1'b0) begin failures++; $display("FAIL rst_tlast got=%b exp=0", m_axis_tlast); end
      checks++; if (m_axis_tdata !== '0) begin failures++; $display("FAIL rst_tdata got=%h exp=0", m_axis_tdata); end
      checks++; if (m_axis_tkeep !== '0) begin failures++; $display("FAIL rst_tkeep got=%h exp=0", m_axis_tkeep); end
      checks++; if (m_axis_tuser !== '0) begin failures++; $display("FAIL rst_tuser got=%h exp=0", m_axis_tuser); end
      checks++; if (pkt_in_cnt !== '0) begin failures++; $display("FAIL rst_in_cnt got=%0d exp=0", pkt_in_cnt); end
      checks++; if (pkt_trunc_cnt !== '0) begin failures++; $display("FAIL rst_trunc_cnt got=%0d exp=0", pkt_trunc_cnt); end
      checks++; if (s_axis_tready !== 1'b1) begin failures++; $display("FAIL rst_tready got=%b exp=1", s_axis_tready); end
      @(negedge axi_aclk);
      axi_reset = 1'b0;
      obs_q.delete();
   endtask

   task automatic test_no_snap();
      beat_t lb;
      ready_mode = 0;
      send_pkt(150, 1'b0, 100, -1);
      wait_drain();
      lb = (obs_q.size() > 0) ? obs_q[obs_q.size() - 1] : '0;
      checks++; if (obs_q.size() != 5) begin failures++; $display("FAIL nosnap_beats got=%0d exp=5", obs_q.size()); end
      checks++; if (lb.keep !== 32'h003F_FFFF) begin failures++; $display("FAIL nosnap_keep got=%h exp=003fffff", lb.keep); end
      checks++; if (lb.user[15:0] !== 16'd150 || lb.last !== 1'b1) begin failures++; $display("FAIL nosnap_len got=%0d/%b exp=150/1", lb.user[15:0], lb.last); end
      checks++; if (pkt_trunc_cnt !== 32'd0) begin failures++; $display("FAIL nosnap_trunc_cnt got=%0d exp=0", pkt_trunc_cnt); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL nosnap_beat%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_snap_100();
      beat_t lb;
      ready_mode = 0;
      gen_pkt(300);
      model_pkt(300, 1'b1, 100);
      for (int k = 0; k < 4; k++) drive_beat(k, 1'b1, 100);
      ready_mode = 2;
      for (int k = 4; k < pk_n; k++) begin
         drive_beat(k, 1'b0, 0);
         checks++;
         if (last_stall != 0) begin failures++; $display("FAIL snap100_drop_stall beat=%0d got=%0d exp=0", k, last_stall); end
      end
      wait_drain();
      lb = (obs_q.size() > 0) ? obs_q[obs_q.size() - 1] : '0;
      checks++; if (obs_q.size() != 4) begin failures++; $display("FAIL snap100_beats got=%0d exp=4", obs_q.size()); end
      checks++; if (lb.keep !== 32'h0000_000F || lb.last !== 1'b1) begin failures++; $display("FAIL snap100_keep got=%h/%b exp=0000000f/1", lb.keep, lb.last); end
      checks++; if (lb.user[15:0] !== 16'd100) begin failures++; $display("FAIL snap100_len got=%0d exp=100", lb.user[15:0]); end
      checks++; if (pkt_trunc_cnt !== 32'd1) begin failures++; $display("FAIL snap100_trunc_cnt got=%0d exp=1", pkt_trunc_cnt); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL snap100_beat%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_floor();
      beat_t lb;
      send_pkt(80, 1'b1, 10, -1);
      wait_drain();
      lb = (obs_q.size() > 0) ? obs_q[obs_q.size() - 1] : '0;
      checks++; if (obs_q.size() != 2) begin failures++; $display("FAIL floor_beats got=%0d exp=2", obs_q.size()); end
      checks++; if (lb.keep !== 32'hFFFF_FFFF || lb.last !== 1'b1) begin failures++; $display("FAIL floor_keep got=%h/%b exp=ffffffff/1", lb.keep, lb.last); end
      checks++; if (lb.user[15:0] !== 16'd64) begin failures++; $display("FAIL floor_len got=%0d exp=64", lb.user[15:0]); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL floor_beat%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_midchange();
      int tc0;
      tc0 = exp_trunc;
      send_pkt(128, 1'b1, 128, 64);
      send_pkt(200, 1'b1, 64, -1);
      wait_drain();
      checks++; if (obs_q.size() != 6) begin failures++; $display("FAIL mid_beats got=%0d exp=6", obs_q.size()); end
      checks++; if (obs_q.size() >= 4 && (obs_q[3].user[15:0] !== 16'd128 || obs_q[3].last !== 1'b1)) begin failures++; $display("FAIL mid_first_len got=%0d/%b exp=128/1", obs_q[3].user[15:0], obs_q[3].last); end
      checks++; if (obs_q.size() >= 6 && obs_q[5].user[15:0] !== 16'd64) begin failures++; $display("FAIL mid_second_len got=%0d exp=64", obs_q[5].user[15:0]); end
      checks++; if (pkt_trunc_cnt !== CW'(exp_trunc) || exp_trunc != tc0 + 1) begin failures++; $display("FAIL mid_trunc_cnt got=%0d exp=%0d", pkt_trunc_cnt, tc0 + 1); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL mid_beat%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_random();
      int len;
      int slen;
      int sel;
      int errs;
      pulse_reset();
      stable_err = 0;
      ready_mode = 1;
      for (int p = 0; p < 1000; p++) begin
         len = int'($urandom_range(1, 400));
         sel = int'($urandom_range(0, 3));
         slen = (sel == 0) ? 0 : (sel == 1) ? int'($urandom_range(1, 63)) : int'($urandom_range(64, 420));
         send_pkt(len, 1'($urandom_range(0, 1)), slen, -1);
      end
      wait_drain();
      checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL rand_beats got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
      checks++; if (pkt_in_cnt !== 32'd1000) begin failures++; $display("FAIL rand_in_cnt got=%0d exp=1000", pkt_in_cnt); end
      checks++; if (pkt_trunc_cnt !== CW'(exp_trunc)) begin failures++; $display("FAIL rand_trunc_cnt got=%0d exp=%0d", pkt_trunc_cnt, exp_trunc); end
      checks++; if (stable_err != 0) begin failures++; $display("FAIL rand_stall_stable got=%0d exp=0", stable_err); end
      errs = 0;
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            failures++;
            errs++;
            if (errs <= 20) $display("FAIL rand_beat%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
         end
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_reset_mid();
      ready_mode = 0;
      gen_pkt(320);
      drive_beat(0, 1'b0, 0);
      drive_beat(1, 1'b0, 0);
      @(negedge axi_aclk);
      s_axis_tdata = pk_data[2];
      s_axis_tkeep = pk_keep[2];
      s_axis_tlast = 1'b0;
      axi_reset    = 1'b1;
      @(posedge axi_aclk);
      #1;
      checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL rstmid_tvalid got=%b exp=0", m_axis_tvalid); end
      checks++; if (pkt_in_cnt !== '0 || pkt_trunc_cnt !== '0) begin failures++; $display("FAIL rstmid_cnt got=%0d/%0d exp=0/0", pkt_in_cnt, pkt_trunc_cnt); end
      @(negedge axi_aclk);
      axi_reset     = 1'b0;
      s_axis_tvalid = 1'b0;
      obs_q.delete(); exp_q.delete();
      exp_in = 0; exp_trunc = 0;
      send_pkt(200, 1'b1, 100, -1);
      wait_drain();
      checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL rstmid_beats got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
      checks++; if (pkt_in_cnt !== 32'd1 || pkt_trunc_cnt !== 32'd1) begin failures++; $display("FAIL rstmid_cnt_after got=%0d/%0d exp=1/1", pkt_in_cnt, pkt_trunc_cnt); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL rstmid_beat%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
      end
      obs_q.delete(); exp_q.delete();
   endtask

   initial begin
      axi_reset     = 1'b1;
      snap_en       = 1'b0;
      snap_len      = '0;
      s_axis_tdata  = '0;
      s_axis_tkeep  = '0;
      s_axis_tuser  = '0;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      test_reset();
      test_no_snap();
      test_snap_100();
      test_floor();
      test_midchange();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
